mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
Parametrised, registered N-channel, W-bit selector; the next generation of the team's 7-to-1 select mux. It adds two selection modes: direct (external select) and auto-scan (round-robin with programmable dwell). Output uses a valid/ready handshake with channel tag and error flag. It sits between sensor/data channel banks and a single downstream consumer.

Parameters:
N, 7, number of input channels (>=2)
W, 1, data width per channel
DWELL, 4, scan-mode cycles per channel before capture (>=1)
SEL_W, $clog2(N), select/channel-tag width (localparam, derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  enable; 0 freezes counters and blocks new captures
mode  in  1  0 = direct select, 1 = auto-scan
sel  in  SEL_W  channel select, direct mode only
in_bus  in  N*W  packed channels; channel k = in_bus[k*W +: W]
z_ready  in  1  downstream accepts z this cycle
z  out  W  captured channel data
z_ch  out  SEL_W  channel index of z
z_valid  out  1  z/z_ch hold an unconsumed sample
sel_err  out  1  last direct-mode load attempt had sel >= N
scan_wrap  out  1  one-cycle pulse when the scan pointer wraps N-1 -> 0

Behaviour:
- Clock: one clock. Reset: asynchronous, active-high. Port names: clk and reset.
- Reset values: z=0, z_ch=0, z_valid=0, sel_err=0, scan_wrap=0, ptr=0, cnt=0, state=S_DIRECT if mode=0, else S_SCAN_CNT.
- slot_free = !z_valid || z_ready. A load happens only when en && slot_free && the mode's capture condition holds.
- Consume: z_valid && z_ready with no load in the same cycle -> z_valid<=0. Consume plus load in the same cycle -> new sample replaces the old one and z_valid stays 1 (throughput 1/cycle).
- Backpressure: while z_valid && !z_ready, z and z_ch are held stable. No sample is dropped or overwritten.
- Direct mode (S_DIRECT):
  - Capture condition: every cycle.
  - sel<N: z<=in[sel], z_ch<=sel, z_valid<=1, sel_err<=0. Latency is 1 cycle from sel/in to z.
  - sel>=N: z and z_ch unchanged, sel_err<=1, and z_valid follows the consume rule. Never output X.
- Scan mode FSM:
  - S_SCAN_CNT: while en, cnt increments each cycle. At cnt==DWELL-1:
    - slot_free -> load in[ptr], z_ch<=ptr, cnt<=0, ptr<=(ptr==N-1)?0:ptr+1, scan_wrap<=(ptr==N-1).
    - otherwise -> go to S_SCAN_HOLD with cnt held.
  - S_SCAN_HOLD: wait for slot_free && en, then load exactly as above and return to S_SCAN_CNT.
  - DWELL=1: capture on every free enabled cycle.
  - First capture occurs DWELL cycles after scan entry with en=1.
  - sel_err is held at its current value in scan mode; sel is ignored.
- Mode change (mode differs from the registered mode):
  - ptr<=0, cnt<=0, move to the new mode's state.
  - A pending valid output is kept until consumed.
  - No load in the switch cycle.
- en=0: cnt, ptr and state frozen, no loads. Consume still works.
- scan_wrap is 0 in every cycle without a wrap load.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending sample is lost.

Decomposition:
- Package mux_pkg:
  - mode encodings MODE_DIRECT=1'b0, MODE_SCAN=1'b1
  - state enum {S_DIRECT, S_SCAN_CNT, S_SCAN_HOLD}
  - helper function for SEL_W
- Sub-module scan_ctr (params N, DWELL): ptr and cnt registers, with inputs clear, advance, count_en and outputs ptr, at_dwell, wrap.
- Top level holds the FSM, output registers and handshake.

Test Plan:
- Direct, N=7, W=8, in[k]=8'h10+k, z_ready=1, sel stepped 0..6 -> z=8'h10..8'h16 one cycle after each sel, z_ch=sel, z_valid=1 continuously, sel_err=0.
- Direct, sel=7 for one cycle after a valid sel=3 load -> sel_err=1; z stays 8'h13; z_valid drops once consumed; next sel=2 -> z=8'h12, sel_err=0.
- Scan, DWELL=4, z_ready=1, en=1 -> captures at cycles 4,8,...,28 with z_ch=0..6; scan_wrap pulses at the channel-6 capture; the next capture is channel 0 at cycle 32.
- Scan, z_ready=0 for 10 cycles after the channel-2 capture -> z=ch2 data held stable, FSM in S_SCAN_HOLD; on z_ready=1, channel 3 loads on that same cycle, with no channel skipped.
- Mode switch from scan (ptr=4) to direct and back to scan -> scan resumes at ptr=0, first capture DWELL cycles later; a pending sample is kept until z_ready.
- Reset asserted asynchronously mid-hold with z_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; after release, scan restarts from channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings, FSM states and width helper for the N-to-1 registered select mux.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    S_DIRECT    = 2'd0,
    S_SCAN_CNT  = 2'd1,
    S_SCAN_HOLD = 2'd2
  } state_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_ctr.sv
// Round-robin scan pointer with a per-channel dwell counter.
module scan_ctr
  import mux_pkg::*;
#(
  parameter  int unsigned N     = 7,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic             count_en,
  output logic [SEL_W-1:0] ptr,
  output logic             at_dwell,
  output logic             wrap
);

  localparam int unsigned CNT_W = sel_width(DWELL);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ptr      = ptr_q;
  assign at_dwell = (cnt_q == CNT_W'(DWELL - 1));
  assign wrap     = (ptr_q == SEL_W'(N - 1));

  // Clear wins over advance; advance restarts the dwell on the next channel.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = '0;
      ptr_d = wrap ? '0 : ptr_q + SEL_W'(1);
    end else if (count_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-channel selector with direct and auto-scan modes and a
// valid/ready output carrying the channel tag.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter  int unsigned N     = 7,
  parameter  int unsigned W     = 1,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_bus,
  input  logic             z_ready,
  output logic [W-1:0]     z,
  output logic [SEL_W-1:0] z_ch,
  output logic             z_valid,
  output logic             sel_err,
  output logic             scan_wrap
);

  state_e           state_q, state_d;
  logic [W-1:0]     z_q, z_d;
  logic [SEL_W-1:0] z_ch_q, z_ch_d;
  logic             z_valid_q, z_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             scan_wrap_q, scan_wrap_d;

  logic             ctr_clear, ctr_advance, ctr_count_en;
  logic [SEL_W-1:0] ptr;
  logic             at_dwell, wrap;

  logic             slot_free, load, cur_mode, sel_ok;
  logic [SEL_W-1:0] idx;
  logic [W-1:0]     ch_data;

  scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan_ctr (
    .clk      (clk),
    .reset    (reset),
    .clear    (ctr_clear),
    .advance  (ctr_advance),
    .count_en (ctr_count_en),
    .ptr      (ptr),
    .at_dwell (at_dwell),
    .wrap     (wrap)
  );

  assign slot_free = !z_valid_q || z_ready;
  assign cur_mode  = (state_q == S_DIRECT) ? MODE_DIRECT : MODE_SCAN;
  assign sel_ok    = (32'(sel) < N);
  assign idx       = (state_q == S_DIRECT) ? sel : ptr;

  // One shared channel mux; out-of-range indices yield zero, never X.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SEL_W'(k)) ch_data = in_bus[k*W +: W];
    end
  end

  always_comb begin
    state_d      = state_q;
    z_d          = z_q;
    z_ch_d       = z_ch_q;
    z_valid_d    = z_valid_q;
    sel_err_d    = sel_err_q;
    scan_wrap_d  = 1'b0;
    ctr_clear    = 1'b0;
    ctr_advance  = 1'b0;
    ctr_count_en = 1'b0;
    load         = 1'b0;

    if (en) begin
      if (mode != cur_mode) begin
        // Switch cycle: restart the scan, keep any pending sample.
        state_d   = (mode == MODE_SCAN) ? S_SCAN_CNT : S_DIRECT;
        ctr_clear = 1'b1;
      end else begin
        unique case (state_q)
          S_DIRECT: begin
            if (slot_free) begin
              if (sel_ok) begin
                load      = 1'b1;
                z_d       = ch_data;
                z_ch_d    = sel;
                sel_err_d = 1'b0;
              end else begin
                sel_err_d = 1'b1;
              end
            end
          end
          S_SCAN_CNT, S_SCAN_HOLD: begin
            if (state_q == S_SCAN_CNT && !at_dwell) begin
              ctr_count_en = 1'b1;
            end else if (slot_free) begin
              load        = 1'b1;
              z_d         = ch_data;
              z_ch_d      = ptr;
              scan_wrap_d = wrap;
              ctr_advance = 1'b1;
              state_d     = S_SCAN_CNT;
            end else begin
              state_d = S_SCAN_HOLD;
            end
          end
          default: state_d = S_DIRECT;
        endcase
      end
    end

    if (load) begin
      z_valid_d = 1'b1;
    end else if (z_valid_q && z_ready) begin
      z_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (mode == MODE_SCAN) ? S_SCAN_CNT : S_DIRECT;
      z_q         <= '0;
      z_ch_q      <= '0;
      z_valid_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      z_ch_q      <= z_ch_d;
      z_valid_q   <= z_valid_d;
      sel_err_q   <= sel_err_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign z         = z_q;
  assign z_ch      = z_ch_q;
  assign z_valid   = z_valid_q;
  assign sel_err   = sel_err_q;
  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan with N=7, W=8, DWELL=4.
module tb_mux_nto1_scan;
  import mux_pkg::*;

  localparam int unsigned N     = 7;
  localparam int unsigned W     = 8;
  localparam int unsigned DWELL = 4;
  localparam int unsigned SEL_W = 3;

  logic             clk;
  logic             reset;
  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   in_bus;
  logic             z_ready;
  logic [W-1:0]     z;
  logic [SEL_W-1:0] z_ch;
  logic             z_valid;
  logic             sel_err;
  logic             scan_wrap;

  int checks = 0;
  int errors = 0;

  mux_nto1_scan #(
    .N     (N),
    .W     (W),
    .DWELL (DWELL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .in_bus    (in_bus),
    .z_ready   (z_ready),
    .z         (z),
    .z_ch      (z_ch),
    .z_valid   (z_valid),
    .sel_err   (sel_err),
    .scan_wrap (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ez, input logic [2:0] ech,
                         input logic ev);
    chk({tag, ".z"}, 32'(z), 32'(ez));
    chk({tag, ".z_ch"}, 32'(z_ch), 32'(ech));
    chk({tag, ".z_valid"}, 32'(z_valid), 32'(ev));
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    mode    = MODE_DIRECT;
    sel     = '0;
    z_ready = 1'b1;
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = 8'(8'h10 + k);
    #1;
    chk_out("reset", 8'h00, 3'd0, 1'b0);
    chk("reset.sel_err", 32'(sel_err), 32'd0);
    chk("reset.scan_wrap", 32'(scan_wrap), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Direct select sweep, one-cycle latency.
    for (int s = 0; s < N; s++) begin
      sel = SEL_W'(s);
      step();
      chk_out($sformatf("direct%0d", s), 8'(8'h10 + s), 3'(s), 1'b1);
      chk($sformatf("direct%0d.sel_err", s), 32'(sel_err), 32'd0);
    end

    // Out-of-range select after a valid load.
    sel = 3'd3;
    step();
    chk_out("sel3", 8'h13, 3'd3, 1'b1);
    sel = 3'd7;
    step();
    chk_out("sel7", 8'h13, 3'd3, 1'b0);
    chk("sel7.sel_err", 32'(sel_err), 32'd1);
    sel = 3'd2;
    step();
    chk_out("sel2", 8'h12, 3'd2, 1'b1);
    chk("sel2.sel_err", 32'(sel_err), 32'd0);

    // Direct backpressure holds the sample.
    z_ready = 1'b0;
    sel     = 3'd5;
    step();
    chk_out("bp_direct", 8'h12, 3'd2, 1'b1);

    // en=0: consume works, no load.
    z_ready = 1'b1;
    en      = 1'b0;
    sel     = 3'd4;
    step();
    chk_out("en0", 8'h12, 3'd2, 1'b0);
    en = 1'b1;

    // Switch to scan; captures every DWELL cycles after the switch edge.
    mode = MODE_SCAN;
    step();
    chk("switch.z_valid", 32'(z_valid), 32'd0);
    for (int c = 0; c <= N; c++) begin
      for (int d = 1; d < DWELL; d++) begin
        step();
        chk($sformatf("scan%0d_wait.z_valid", c), 32'(z_valid), 32'd0);
        chk($sformatf("scan%0d_wait.wrap", c), 32'(scan_wrap), 32'd0);
      end
      step();
      chk_out($sformatf("scan%0d", c), 8'(8'h10 + (c % N)), 3'(c % N), 1'b1);
      chk($sformatf("scan%0d.wrap", c), 32'(scan_wrap), 32'(c == N - 1));
    end

    // Advance to channel 2, then stall the consumer for 10 cycles.
    for (int c = 1; c <= 2; c++) begin
      for (int d = 0; d < DWELL; d++) step();
      chk_out($sformatf("pre_hold%0d", c), 8'(8'h10 + c), 3'(c), 1'b1);
    end
    z_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 8'h12, 3'd2, 1'b1);
    end
    chk("hold.state", 32'(dut.state_q), 32'(S_SCAN_HOLD));
    z_ready = 1'b1;
    step();
    chk_out("hold_release", 8'h13, 3'd3, 1'b1);

    // Mode round-trip with ptr=4 and a pending sample.
    z_ready = 1'b0;
    mode    = MODE_DIRECT;
    step();
    chk_out("to_direct", 8'h13, 3'd3, 1'b1);
    mode = MODE_SCAN;
    step();
    chk_out("to_scan", 8'h13, 3'd3, 1'b1);
    z_ready = 1'b1;
    step();
    chk_out("resume1", 8'h13, 3'd3, 1'b0);
    step();
    step();
    chk("resume3.z_valid", 32'(z_valid), 32'd0);
    step();
    chk_out("resume_ch0", 8'h10, 3'd0, 1'b1);

    // Stall into hold on channel 1, then reset asynchronously.
    z_ready = 1'b0;
    for (int d = 0; d < DWELL; d++) step();
    chk("prerst.state", 32'(dut.state_q), 32'(S_SCAN_HOLD));
    chk_out("prerst", 8'h10, 3'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0);
    chk("async_rst.state", 32'(dut.state_q), 32'(S_SCAN_CNT));
    #1;
    reset   = 1'b0;
    z_ready = 1'b1;
    for (int d = 1; d < DWELL; d++) step();
    chk("post_rst3.z_valid", 32'(z_valid), 32'd0);
    step();
    chk_out("post_rst_ch0", 8'h10, 3'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
